// File: rtl/pwm_pkg.sv
// Shared gate-path definitions: leg state encoding and dead-time counter helpers.
package pwm_pkg;

  localparam int unsigned DT_CNT_W = 8;
  localparam int unsigned DT_MAX   = (2 ** DT_CNT_W) - 1;
  localparam logic [DT_CNT_W-1:0] DT_ONE = {{(DT_CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LEG_OFF   = 2'd0,
    LEG_HI    = 2'd1,
    LEG_LO    = 2'd2,
    LEG_FAULT = 2'd3
  } leg_state_e;

  function automatic logic [DT_CNT_W-1:0] sat_dec(input logic [DT_CNT_W-1:0] v);
    return (v == {DT_CNT_W{1'b0}}) ? v : (v - DT_ONE);
  endfunction

  function automatic logic [DT_CNT_W-1:0] sat_inc(input logic [DT_CNT_W-1:0] v);
    return (v == {DT_CNT_W{1'b1}}) ? v : (v + DT_ONE);
  endfunction

endpackage

// File: rtl/dt_leg.sv
// One half-bridge leg: command synchroniser, dead-time counter and interlock FSM.
// Optional minimum on-command qualification under DT_MIN_PULSE_EN.
module dt_leg
  import pwm_pkg::*;
#(
  parameter int unsigned DT_CYCLES = 50
`ifdef DT_MIN_PULSE_EN
  , parameter int unsigned MIN_PULSE = 10
`endif
) (
  input  logic CLK_50M,
  input  logic Rst,
  input  logic En,
  input  logic Flt_Clr,
  input  logic pwm_h_d,
  input  logic pwm_l_d,
  output logic pwm_h,
  output logic pwm_l,
  output logic shoot_flt
);

  localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DT_CYCLES);

  logic h_meta_r, l_meta_r, cmd_h_r, cmd_l_r;
  leg_state_e state_r;
  logic [DT_CNT_W-1:0] dt_cnt_r;
  logic flt_r, pwm_h_r, pwm_l_r;
  logic dt_done_s, qual_ok_s;

  // Two-flop synchroniser for the asynchronous pad commands
  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      h_meta_r <= 1'b0;
      l_meta_r <= 1'b0;
      cmd_h_r  <= 1'b0;
      cmd_l_r  <= 1'b0;
    end else begin
      h_meta_r <= pwm_h_d;
      l_meta_r <= pwm_l_d;
      cmd_h_r  <= h_meta_r;
      cmd_l_r  <= l_meta_r;
    end
  end

`ifdef DT_MIN_PULSE_EN
  localparam logic [DT_CNT_W-1:0] QUAL_LEN = DT_CNT_W'(MIN_PULSE);
  logic [DT_CNT_W-1:0] qual_cnt_r, qual_cnt_s;
  logic prev_h_r, prev_l_r;

  // Run length of the current single-direction command, this cycle included
  always_comb begin
    qual_cnt_s = {DT_CNT_W{1'b0}};
    if ((cmd_h_r && !cmd_l_r && prev_h_r) || (cmd_l_r && !cmd_h_r && prev_l_r)) begin
      qual_cnt_s = sat_inc(qual_cnt_r);
    end else if (cmd_h_r ^ cmd_l_r) begin
      qual_cnt_s = DT_ONE;
    end else begin
      qual_cnt_s = {DT_CNT_W{1'b0}};
    end
  end

  // Qualification counter state; restarts whenever the command drops or flips
  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      qual_cnt_r <= {DT_CNT_W{1'b0}};
      prev_h_r   <= 1'b0;
      prev_l_r   <= 1'b0;
    end else begin
      qual_cnt_r <= qual_cnt_s;
      prev_h_r   <= cmd_h_r;
      prev_l_r   <= cmd_l_r;
    end
  end

  assign qual_ok_s = (qual_cnt_s >= QUAL_LEN);
`else
  assign qual_ok_s = 1'b1;
`endif

  // Turn-on is allowed on the cycle the count expires, giving a gap of exactly DT_CYCLES edges
  assign dt_done_s = (dt_cnt_r <= DT_ONE);

  // Leg interlock FSM with registered gate outputs
  always_ff @(posedge CLK_50M or posedge Rst) begin
    if (Rst) begin
      state_r  <= LEG_OFF;
      dt_cnt_r <= DT_LOAD;
      flt_r    <= 1'b0;
      pwm_h_r  <= 1'b0;
      pwm_l_r  <= 1'b0;
    end else if (cmd_h_r && cmd_l_r) begin
      state_r  <= LEG_FAULT;
      dt_cnt_r <= DT_LOAD;
      flt_r    <= 1'b1;
      pwm_h_r  <= 1'b0;
      pwm_l_r  <= 1'b0;
    end else if (!En) begin
      state_r  <= (state_r == LEG_FAULT) ? LEG_FAULT : LEG_OFF;
      dt_cnt_r <= DT_LOAD;
      pwm_h_r  <= 1'b0;
      pwm_l_r  <= 1'b0;
    end else begin
      case (state_r)
        LEG_HI: begin
          dt_cnt_r <= DT_LOAD;
          pwm_l_r  <= 1'b0;
          if (!cmd_h_r) begin
            state_r <= LEG_OFF;
            pwm_h_r <= 1'b0;
          end else begin
            pwm_h_r <= 1'b1;
          end
        end
        LEG_LO: begin
          dt_cnt_r <= DT_LOAD;
          pwm_h_r  <= 1'b0;
          if (!cmd_l_r) begin
            state_r <= LEG_OFF;
            pwm_l_r <= 1'b0;
          end else begin
            pwm_l_r <= 1'b1;
          end
        end
        LEG_OFF: begin
          dt_cnt_r <= sat_dec(dt_cnt_r);
          if (cmd_h_r && dt_done_s && qual_ok_s) begin
            state_r <= LEG_HI;
            pwm_h_r <= 1'b1;
            pwm_l_r <= 1'b0;
          end else if (cmd_l_r && dt_done_s && qual_ok_s) begin
            state_r <= LEG_LO;
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b1;
          end else begin
            pwm_h_r <= 1'b0;
            pwm_l_r <= 1'b0;
          end
        end
        LEG_FAULT: begin
          pwm_h_r <= 1'b0;
          pwm_l_r <= 1'b0;
          if (Flt_Clr && !cmd_h_r && !cmd_l_r) begin
            state_r  <= LEG_OFF;
            flt_r    <= 1'b0;
            dt_cnt_r <= DT_LOAD;
          end else begin
            dt_cnt_r <= sat_dec(dt_cnt_r);
          end
        end
        default: begin
          state_r  <= LEG_OFF;
          dt_cnt_r <= DT_LOAD;
          pwm_h_r  <= 1'b0;
          pwm_l_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_h     = pwm_h_r;
  assign pwm_l     = pwm_l_r;
  assign shoot_flt = flt_r;

endmodule

// File: rtl/pwm_deadtime.sv
// Dead-time insertion and shoot-through interlock for N_LEGS half-bridge legs.
// Define DT_MIN_PULSE_EN to add minimum on-command qualification (MIN_PULSE cycles).
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned N_LEGS    = 4,
  parameter int unsigned DT_CYCLES = 50,
  parameter int unsigned MIN_PULSE = 10
) (
  input  logic              CLK_50M,
  input  logic              Rst,
  input  logic              En,
  input  logic [N_LEGS-1:0] Pwm_H_D,
  input  logic [N_LEGS-1:0] Pwm_L_D,
  input  logic              Flt_Clr,
  output logic [N_LEGS-1:0] Pwm_H,
  output logic [N_LEGS-1:0] Pwm_L,
  output logic [N_LEGS-1:0] Shoot_Flt
);

  if (DT_CYCLES < 1 || DT_CYCLES > DT_MAX || MIN_PULSE < 1 || MIN_PULSE > DT_MAX) begin : g_bad_param
    $error("pwm_deadtime: DT_CYCLES and MIN_PULSE must lie in 1..255");
  end

  for (genvar g = 0; g < N_LEGS; g++) begin : g_leg
    dt_leg #(
      .DT_CYCLES(DT_CYCLES)
`ifdef DT_MIN_PULSE_EN
      , .MIN_PULSE(MIN_PULSE)
`endif
    ) u_leg (
      .CLK_50M  (CLK_50M),
      .Rst      (Rst),
      .En       (En),
      .Flt_Clr  (Flt_Clr),
      .pwm_h_d  (Pwm_H_D[g]),
      .pwm_l_d  (Pwm_L_D[g]),
      .pwm_h    (Pwm_H[g]),
      .pwm_l    (Pwm_L[g]),
      .shoot_flt(Shoot_Flt[g])
    );
  end

endmodule
